// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, polarity constants and hex glyphs for the 7-segment display path
// Contents: digit_idx_t (2-bit digit index), NUM_DIGITS, seg_off/an_off
//           (all-dark bus values per polarity), hex2seg (0-F glyphs, {g,f,e,d,c,b,a}, 1 = lit)
package seg7_pkg;
   localparam int NUM_DIGITS = 4;
   typedef logic [1:0] digit_idx_t;
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };
   function automatic logic [6:0] seg_off(input bit active_low);
      return active_low ? 7'h7F : 7'h00;
   endfunction
   function automatic logic [NUM_DIGITS-1:0] an_off(input bit active_low);
      return active_low ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
   endfunction
   function automatic logic [6:0] hex2seg(input logic [3:0] nib);
      return HEX_SEG[nib];
   endfunction
endpackage

// File: rtl/seg7_refresh_timer.sv
// seg7_refresh_timer: slot divider and digit selector for the scan multiplexer
// Ports: i_clk, i_reset (sync, active-high), o_div_cnt (position within slot),
//        o_slot_tick (last cycle of slot), o_digit_sel (digit being scanned)
module seg7_refresh_timer
   import seg7_pkg::*;
#(
   parameter int DIV_WIDTH = 16,
   parameter int DIV_MAX   = 49999
)(
   input  logic                 i_clk,
   input  logic                 i_reset,
   output logic [DIV_WIDTH-1:0] o_div_cnt,
   output logic                 o_slot_tick,
   output digit_idx_t           o_digit_sel
);
   localparam logic [DIV_WIDTH-1:0] MAX = DIV_WIDTH'(DIV_MAX);
   logic [DIV_WIDTH-1:0] r_div_cnt;
   digit_idx_t           r_digit_sel;
   assign o_div_cnt   = r_div_cnt;
   assign o_digit_sel = r_digit_sel;
   assign o_slot_tick = (r_div_cnt == MAX);
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_div_cnt   <= '0;
         r_digit_sel <= '0;
      end else begin
         r_div_cnt <= o_slot_tick ? '0 : r_div_cnt + 1'b1;
         if (o_slot_tick) r_digit_sel <= r_digit_sel + 1'b1;
      end
   end
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: four-digit 7-segment scan multiplexer with frame snapshot and duty control
// Ports: clk, reset (sync, active-high), digit0..digit3 (patterns, digit0 rightmost),
//        blank (per-digit dark request), seg (shared segment bus), an (anode select),
//        frame_start (one-cycle pulse on the first cycle of a new frame)
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int DIV_WIDTH  = 16,
   parameter int DIV_MAX    = 49999,
   parameter int ON_CYCLES  = 40000,
   parameter bit ACTIVE_LOW = 1'b1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            digit0,
   input  logic [6:0]            digit1,
   input  logic [6:0]            digit2,
   input  logic [6:0]            digit3,
   input  logic [NUM_DIGITS-1:0] blank,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  frame_start
);
   localparam logic [6:0]            SEG_OFF = seg_off(ACTIVE_LOW);
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = an_off(ACTIVE_LOW);
   // One extra bit so ON_CYCLES = DIV_MAX+1 = 2^DIV_WIDTH still means full on
   localparam logic [DIV_WIDTH:0]    ON_LIM  = (DIV_WIDTH+1)'(ON_CYCLES);
   logic [DIV_WIDTH-1:0]            w_div_cnt;
   logic                            w_slot_tick;
   digit_idx_t                      w_sel;
   logic                            w_snap;
   logic                            w_lit;
   logic [NUM_DIGITS-1:0][6:0]      r_shadow;
   logic [NUM_DIGITS-1:0]           r_blank;
   seg7_refresh_timer #(
      .DIV_WIDTH (DIV_WIDTH),
      .DIV_MAX   (DIV_MAX)
   ) u_timer (
      .i_clk       (clk),
      .i_reset     (reset),
      .o_div_cnt   (w_div_cnt),
      .o_slot_tick (w_slot_tick),
      .o_digit_sel (w_sel)
   );
   // Snapshot on the last cycle of digit 3 so the whole next frame uses one consistent set
   assign w_snap = w_slot_tick && (w_sel == digit_idx_t'(NUM_DIGITS-1));
   assign w_lit  = ({1'b0, w_div_cnt} < ON_LIM) && !r_blank[w_sel];
   // seg and an share one edge so a new anode never shows the previous digit's segments;
   // XOR with the off value applies the pin polarity
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shadow    <= '0;
         r_blank     <= '1;
         seg         <= SEG_OFF;
         an          <= AN_OFF;
         frame_start <= 1'b0;
      end else begin
         if (w_snap) begin
            r_shadow <= {digit3, digit2, digit1, digit0};
            r_blank  <= blank;
         end
         frame_start <= w_snap;
         seg         <= w_lit ? r_shadow[w_sel] ^ SEG_OFF : SEG_OFF;
         an          <= w_lit ? (NUM_DIGITS'(1) << w_sel) ^ AN_OFF : AN_OFF;
      end
   end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: scoreboard bench for seg7_scan_mux at DIV_MAX=3 with ON_CYCLES 3, 0 and 4
module tb_seg7_scan_mux;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] d0, d1, d2, d3;
   logic [3:0] blank;
   logic [6:0] seg3, seg0, seg4;
   logic [3:0] an3, an0, an4;
   logic       fs3, fs0, fs4;
   typedef struct packed {
      logic [3:0] an3, an0, an4;
      logic [6:0] seg3, seg0, seg4;
      logic       fs;
   } exp_t;
   exp_t q[$];
   int checks = 0;
   int passed = 0;
   always #5 clk = ~clk;
   seg7_scan_mux #(.DIV_WIDTH(4), .DIV_MAX(3), .ON_CYCLES(3), .ACTIVE_LOW(1'b1)) u_on3 (
      .clk(clk), .reset(reset), .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
      .blank(blank), .seg(seg3), .an(an3), .frame_start(fs3));
   seg7_scan_mux #(.DIV_WIDTH(4), .DIV_MAX(3), .ON_CYCLES(0), .ACTIVE_LOW(1'b1)) u_on0 (
      .clk(clk), .reset(reset), .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
      .blank(blank), .seg(seg0), .an(an0), .frame_start(fs0));
   seg7_scan_mux #(.DIV_WIDTH(4), .DIV_MAX(3), .ON_CYCLES(4), .ACTIVE_LOW(1'b1)) u_on4 (
      .clk(clk), .reset(reset), .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
      .blank(blank), .seg(seg4), .an(an4), .frame_start(fs4));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
   endtask
   // Output in cycle p reflects the evaluation in cycle p-1 (slot (p-1)/4, offset (p-1)%4)
   function automatic void model(input int p, input int on, input logic [3:0][6:0] sd,
                                 input logic [3:0] sb, output logic [3:0] an, output logic [6:0] sg);
      int s, c;
      an = 4'hF;
      sg = 7'h7F;
      if (p > 0) begin
         s = ((p - 1) / 4) % 4;
         c = (p - 1) % 4;
         if (c < on && !sb[s]) begin
            an = ~(4'b0001 << s);
            sg = ~sd[s];
         end
      end
   endfunction
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("an_on3", an3, e.an3);
         chk("seg_on3", seg3, e.seg3);
         chk("fs_on3", fs3, e.fs);
         chk("an_on0", an0, e.an0);
         chk("seg_on0", seg0, e.seg0);
         chk("an_on4", an4, e.an4);
         chk("seg_on4", seg4, e.seg4);
         chk("fs_on4", fs4, e.fs);
      end
   end
   initial begin
      logic [3:0][6:0] snap_d, nxt_d;
      logic [3:0]      snap_b, nxt_b;
      exp_t            e;
      int              p;
      d0 = 7'h3F; d1 = 7'h06; d2 = 7'h5B; d3 = 7'h4F; blank = 4'b0000;
      snap_d = '0; snap_b = 4'hF; nxt_d = '0; nxt_b = 4'hF;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      p = 0;
      for (int t = 0; t < 140; t++) begin
         if (t == 21) d2 = 7'h66;
         if (t == 40) blank = 4'b0101;
         if (t == 56) blank = 4'b0000;
         if (p % 16 == 1 && p > 1) begin
            snap_d = nxt_d;
            snap_b = nxt_b;
         end
         model(p, 3, snap_d, snap_b, e.an3, e.seg3);
         model(p, 0, snap_d, snap_b, e.an0, e.seg0);
         model(p, 4, snap_d, snap_b, e.an4, e.seg4);
         e.fs = (p > 0 && p % 16 == 0);
         q.push_back(e);
         if (p % 16 == 15) begin
            nxt_d = {d3, d2, d1, d0};
            nxt_b = blank;
         end
         reset = (t == 73);
         @(posedge clk);
         #1;
         if (reset) begin
            reset = 1'b0;
            p = 0;
            snap_d = '0;
            snap_b = 4'hF;
         end else p++;
      end
      @(negedge clk);
      #1;
      chk("scoreboard_drained", q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
